seq_multiplier: RTL

Parametrised sequential shift-and-add multiplier, successor to the 2-bit combinational multiplier. Takes two WIDTH-bit operands, unsigned or two's-complement (selected per operation), computes the 2·WIDTH-bit product over WIDTH iterations, and reports completion with a start/busy/done handshake. Sits in the lab datapath wherever area matters more than latency, with one adder shared across all iterations.

---
 rtl/seq_multiplier_pkg.sv | 15 +
 rtl/seq_multiplier_shift_add_step.sv | 24 ++
 rtl/seq_multiplier.sv | 107 ++++++++++
 3 files changed

// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier: FSM state
// encoding and the iteration-counter width helper.
package seq_multiplier_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter must hold values up to WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/seq_multiplier_shift_add_step.sv
// One shift-and-add iteration: conditionally add the multiplicand into the upper
// half of the product register, then shift right with the carry entering the MSB.
module seq_multiplier_shift_add_step
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [2*WIDTH-1:0] p,
    input  logic [WIDTH-1:0]   mcand,
    output logic [2*WIDTH-1:0] p_next
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        if (p[0]) begin
            p_next = {sum, p[WIDTH-1:1]};
        end else begin
            p_next = {1'b0, p[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential WIDTH x WIDTH multiplier, unsigned or two's complement per operation.
// Operates on magnitudes with one shared adder and applies the sign at completion.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sgn,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] y
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam int PW    = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    state_t             state_next;
    logic               load;
    logic               step;
    logic               last_iter;
    logic               neg;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [PW-1:0]      p;
    logic [PW-1:0]      p_step;
    logic [CNT_W-1:0]   count;

    // Magnitude of the most negative value wraps to itself, read as unsigned.
    assign a_mag = (sgn && A[WIDTH-1]) ? (WIDTH'(0) - A) : A;
    assign b_mag = (sgn && B[WIDTH-1]) ? (WIDTH'(0) - B) : B;

    seq_multiplier_shift_add_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p      (p),
        .mcand  (mcand),
        .p_next (p_step)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start)     state_next = ST_RUN;
            ST_RUN:  if (last_iter) state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        load = 1'b0;
        step = 1'b0;
        busy = 1'b0;
        case (state)
            ST_IDLE: load = start;
            ST_RUN: begin
                step = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    assign last_iter = step && (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            p     <= '0;
            neg   <= 1'b0;
            count <= '0;
            y     <= '0;
            done  <= 1'b0;
        end else begin
            done <= last_iter;
            if (load) begin
                mcand <= a_mag;
                p     <= {{WIDTH{1'b0}}, b_mag};
                neg   <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                count <= '0;
            end else if (step) begin
                p     <= p_step;
                count <= count + CNT_W'(1);
            end
            // The result register only ever sees the finished product.
            if (last_iter) begin
                y <= neg ? (PW'(0) - p_step) : p_step;
            end
        end
    end

endmodule
